// File: rtl/oser_link_ctrl_if.sv
// Upstream word stream into oser_link_ctrl.
//   s_valid : source has a word on s_data
//   s_ready : controller accepts the word on this cycle's rising edge
//   s_data  : LANES words of 10 bits; lane k occupies bits [10k+9:10k]
// master = upstream source, slave = oser_link_ctrl.
interface oser_link_ctrl_if #(
   parameter int unsigned LANES = 4
);
   logic                  s_valid;
   logic                  s_ready;
   logic [LANES*10-1:0]   s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/oser_link_ctrl.sv
// Bring-up sequencer and word scheduler for a bank of 10:1 output serializers.
// Holds the serializers in reset, lets them settle on idle, sends a training
// word, then streams upstream words and fills underflow cycles with idle.
// Ports:
//   clk_par       : word-rate clock, all logic on its rising edge
//   srst          : synchronous active-high reset, highest priority
//   enable        : link enable; low forces OFF
//   restart       : re-runs bring-up from RST_HOLD (ignored in OFF)
//   src           : upstream valid/ready word stream (slave side)
//   ser_rst       : registered serializer reset, active-high
//   ser_d         : registered serializer parallel words, LANES x 10 bits
//   link_up       : registered, high only in RUN
//   underflow_cnt : saturating count of RUN cycles that had no word offered
module oser_link_ctrl #(
   parameter int unsigned LANES      = 4,
   parameter int unsigned RST_CYC    = 8,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned TRAIN_CYC  = 16,
   parameter logic [9:0]  TRAIN_WORD = 10'h354,
   parameter logic [9:0]  IDLE_WORD  = 10'h0AB
) (
   input  logic                clk_par,
   input  logic                srst,
   input  logic                enable,
   input  logic                restart,
   oser_link_ctrl_if.slave     src,
   output logic                ser_rst,
   output logic [LANES*10-1:0] ser_d,
   output logic                link_up,
   output logic [15:0]         underflow_cnt
);

   localparam int unsigned MAX_A   = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > TRAIN_CYC) ? MAX_A : TRAIN_CYC;
   localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] TRAIN_LAST  = CW'(TRAIN_CYC - 1);

   localparam logic [LANES*10-1:0] IDLE_BUS  = {LANES{IDLE_WORD}};
   localparam logic [LANES*10-1:0] TRAIN_BUS = {LANES{TRAIN_WORD}};

   typedef enum logic [2:0] {
      OFF,
      RST_HOLD,
      SETTLE,
      TRAIN,
      RUN
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ser_rst_d;
   logic                link_up_d;
   logic [LANES*10-1:0] ser_d_d;
   logic [15:0]         ucnt_d;
   logic                ready;
   logic                fire;

   // Ready is gated by enable/restart so a word offered on a cycle that
   // leaves RUN is never taken and then dropped.
   assign ready         = link_up & enable & ~restart;
   assign fire          = ready & src.s_valid;
   assign src.s_ready   = ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ser_rst_d = 1'b1;
      link_up_d = 1'b0;
      ser_d_d   = '0;
      ucnt_d    = underflow_cnt;

      unique case (state_q)
         OFF:      if (enable)              state_d = RST_HOLD;
         RST_HOLD: if (cnt_q == RST_LAST)    state_d = SETTLE;
         SETTLE:   if (cnt_q == SETTLE_LAST) state_d = TRAIN;
         TRAIN:    if (cnt_q == TRAIN_LAST)  state_d = RUN;
         RUN:      state_d = RUN;
         default:  state_d = OFF;
      endcase

      if (restart && (state_q != OFF)) state_d = RST_HOLD;
      if (!enable)                     state_d = OFF;

      // Counter restarts on every entry, including RST_HOLD re-entry from a
      // held restart; it only runs in the timed states.
      if ((state_d != state_q) || restart)
         cnt_d = '0;
      else if ((state_q == RST_HOLD) || (state_q == SETTLE) || (state_q == TRAIN))
         cnt_d = cnt_q + 1'b1;

      // Outputs are registered from the next state so they track the state
      // one edge after the decision.
      unique case (state_d)
         OFF, RST_HOLD: begin
            ser_rst_d = 1'b1;
            ser_d_d   = '0;
         end
         SETTLE: begin
            ser_rst_d = 1'b0;
            ser_d_d   = IDLE_BUS;
         end
         TRAIN: begin
            ser_rst_d = 1'b0;
            ser_d_d   = TRAIN_BUS;
         end
         RUN: begin
            ser_rst_d = 1'b0;
            link_up_d = 1'b1;
            ser_d_d   = fire ? src.s_data : IDLE_BUS;
         end
         default: begin
            ser_rst_d = 1'b1;
            ser_d_d   = '0;
         end
      endcase

      if (ready && !src.s_valid && (underflow_cnt != 16'hFFFF))
         ucnt_d = underflow_cnt + 16'd1;
   end

   always_ff @(posedge clk_par) begin
      if (srst) begin
         state_q       <= OFF;
         cnt_q         <= '0;
         ser_rst       <= 1'b1;
         ser_d         <= '0;
         link_up       <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ser_rst       <= ser_rst_d;
         ser_d         <= ser_d_d;
         link_up       <= link_up_d;
         underflow_cnt <= ucnt_d;
      end
   end

endmodule

// File: tb/tb_oser_link_ctrl.sv
// Self-checking bench for oser_link_ctrl. A timeline model (cycles elapsed
// since the last RST_HOLD entry) predicts every output each cycle; a few
// hand-computed literals pin the model's bring-up length, counts and order.
module tb_oser_link_ctrl;

   localparam int unsigned LANES  = 4;
   localparam int unsigned W      = LANES * 10;
   localparam int          R_CYC  = 8;
   localparam int          S_CYC  = 4;
   localparam int          T_CYC  = 16;
   localparam int          BRING  = R_CYC + S_CYC + T_CYC;
   localparam logic [W-1:0] IDLE_BUS  = {LANES{10'h0AB}};
   localparam logic [W-1:0] TRAIN_BUS = {LANES{10'h354}};

   logic          clk_par = 1'b0;
   logic          srst = 1'b1;
   logic          enable = 1'b0;
   logic          restart = 1'b0;
   logic          ser_rst;
   logic [W-1:0]  ser_d;
   logic          link_up;
   logic [15:0]   underflow_cnt;

   oser_link_ctrl_if #(.LANES(LANES)) s_if ();

   oser_link_ctrl #(
      .LANES(LANES),
      .RST_CYC(R_CYC),
      .SETTLE_CYC(S_CYC),
      .TRAIN_CYC(T_CYC),
      .TRAIN_WORD(10'h354),
      .IDLE_WORD(10'h0AB)
   ) dut (
      .clk_par(clk_par),
      .srst(srst),
      .enable(enable),
      .restart(restart),
      .src(s_if),
      .ser_rst(ser_rst),
      .ser_d(ser_d),
      .link_up(link_up),
      .underflow_cnt(underflow_cnt)
   );

   always #5 clk_par = ~clk_par;

   int checks = 0;
   int failures = 0;

   // Model: off flag, cycles since RST_HOLD entry, underflow count.
   bit m_off = 1'b1;
   int m_t = 0;
   int m_ucnt = 0;
   bit last_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_link();
      return !m_off && (m_t >= BRING);
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   task automatic step(input bit rs_i, input bit en_i, input bit rt_i,
                       input bit sv_i, input logic [W-1:0] sd_i);
      bit           rdy;
      bit           exp_rst;
      logic [W-1:0] exp_d;
      srst          = rs_i;
      enable        = en_i;
      restart       = rt_i;
      s_if.s_valid  = sv_i;
      s_if.s_data   = sd_i;
      #1;
      rdy = m_link() && en_i && !rt_i && !rs_i;
      last_ready = s_if.s_ready;
      if (!rs_i) check("s_ready", s_if.s_ready, rdy);

      if (rs_i) begin
         m_off = 1'b1; m_t = 0; m_ucnt = 0;
      end else if (!en_i) begin
         m_off = 1'b1; m_t = 0;
      end else if (m_off) begin
         m_off = 1'b0; m_t = 0;
      end else if (rt_i) begin
         m_t = 0;
      end else if (m_t < BRING) begin
         m_t++;
      end
      if (rdy && !sv_i && m_ucnt < 65535) m_ucnt++;

      if (m_off || m_t < R_CYC) begin
         exp_rst = 1'b1; exp_d = '0;
      end else if (m_t < R_CYC + S_CYC) begin
         exp_rst = 1'b0; exp_d = IDLE_BUS;
      end else if (m_t < BRING) begin
         exp_rst = 1'b0; exp_d = TRAIN_BUS;
      end else begin
         exp_rst = 1'b0; exp_d = (rdy && sv_i) ? sd_i : IDLE_BUS;
      end

      @(posedge clk_par);
      #1;
      check("ser_rst", ser_rst, exp_rst);
      check("ser_d", ser_d, exp_d);
      check("link_up", link_up, m_link());
      check("underflow_cnt", underflow_cnt, m_ucnt);
   endtask

   // First step leaves OFF (or restarts); then steps until link_up, bounded.
   task automatic bring_up(input bit via_restart, output int n, output int r_hi,
                           output int idl, output int trn);
      n = 0; r_hi = 0; idl = 0; trn = 0;
      step(1'b0, 1'b1, via_restart, 1'b0, rnd_word());
      if (ser_rst) r_hi++;
      while (!link_up && n < 100) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, rnd_word());
         n++;
         if (ser_rst) r_hi++;
         if (!link_up && ser_d == IDLE_BUS) idl++;
         if (ser_d == TRAIN_BUS) trn++;
      end
   endtask

   initial begin
      int n, r_hi, idl, trn;
      logic [9:0] lane0_q[$];
      logic [W-1:0] w;

      // Reset with enable already high.
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("rst_ser_rst", ser_rst, 1'b1);
      check("rst_ser_d", ser_d, '0);
      check("rst_link_up", link_up, 1'b0);
      check("rst_underflow", underflow_cnt, 16'd0);

      bring_up(1'b0, n, r_hi, idl, trn);
      check("bringup_len", n, 28);
      check("bringup_rst_cycles", r_hi, 8);
      check("bringup_idle_cycles", idl, 4);
      check("bringup_train_cycles", trn, 16);
      check("bringup_s_ready", s_if.s_ready, 1'b1);

      // Ramp on lane0, streaming without gaps.
      for (int i = 0; i < 100; i++) begin
         w = rnd_word();
         w[9:0] = 10'(i);
         step(1'b0, 1'b1, 1'b0, 1'b1, w);
         lane0_q.push_back(ser_d[9:0]);
      end
      for (int i = 0; i < 100; i++) check("ramp_lane0", lane0_q[i], 10'(i));
      check("ramp_underflow", underflow_cnt, 16'd0);

      // Alternating valid.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, (i % 2) == 0, rnd_word());
      check("toggle_underflow", underflow_cnt, 16'd10);

      // Restart from RUN, then again in TRAIN cycle 5 of 16.
      step(1'b0, 1'b1, 1'b1, 1'b1, rnd_word());
      repeat (R_CYC + S_CYC + 5) step(1'b0, 1'b1, 1'b0, 1'b0, rnd_word());
      check("pre_restart_train", ser_d, TRAIN_BUS);
      bring_up(1'b1, n, r_hi, idl, trn);
      check("restart_len", n, 28);
      check("restart_rst_cycles", r_hi, 8);
      check("restart_keeps_underflow", underflow_cnt, 16'd10);

      // Held restart keeps RST_HOLD.
      repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, rnd_word());
      check("held_restart_rst", ser_rst, 1'b1);
      repeat (BRING + 1) step(1'b0, 1'b1, 1'b0, 1'b0, rnd_word());

      // Enable dropped for one cycle with a word offered.
      step(1'b0, 1'b0, 1'b0, 1'b1, rnd_word());
      check("endrop_s_ready", last_ready, 1'b0);
      check("endrop_ser_d", ser_d, '0);
      bring_up(1'b0, n, r_hi, idl, trn);
      check("endrop_len", n, 28);

      // Randomized traffic with occasional restart and enable drops.
      for (int i = 0; i < 3000; i++) begin
         step(1'b0, ($urandom_range(127) != 0), ($urandom_range(63) == 0),
              $urandom_range(1) == 1, rnd_word());
      end

      // Saturation of the underflow counter.
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      bring_up(1'b0, n, r_hi, idl, trn);
      repeat (65540) step(1'b0, 1'b1, 1'b0, 1'b0, rnd_word());
      check("sat_underflow", underflow_cnt, 16'hFFFF);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, rnd_word());
      check("sat_hold", underflow_cnt, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
